// File: rtl/mem_port_arbiter_pkg.sv
// Shared bus types and arbiter constants for the memory port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_port_arbiter_pkg;

    localparam int STARVE_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [63:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/mem_req_latch.sv
// Captures the granted request fields and holds them for the whole transaction.
// Latency: fields visible the cycle after load.
// Backpressure: none; load is only pulsed by the arbiter on a grant.
module mem_req_latch
    import mem_port_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [63:0] new_addr,
    input  logic [2:0]  new_size,
    input  logic [7:0]  new_strobe,
    input  logic [63:0] new_data,
    output logic [63:0] addr,
    output logic [2:0]  size,
    output logic [7:0]  strobe,
    output logic [63:0] data
);

    // Hold fields until the next grant so upstream changes cannot leak into memory.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr   <= '0;
            size   <= '0;
            strobe <= '0;
            data   <= '0;
        end else if (load) begin
            addr   <= new_addr;
            size   <= new_size;
            strobe <= new_strobe;
            data   <= new_data;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates ibus fetches and dbus accesses onto one single-beat memory port.
// Latency: grant on the edge after a request, completion on ready+last (>= 2 cycles).
// Backpressure: requesters wait in IDLE; dbus wins unless ibus starved STARVE_MAX grants.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  ireq,
    output ibus_resp_t iresp,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output cbus_req_t  mreq,
    input  cbus_resp_t mresp
);

    localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_CNT_W'(STARVE_MAX);
    localparam logic [STARVE_CNT_W-1:0] CNT_ONE    = STARVE_CNT_W'(1);

    arb_state_t              state;
    arb_state_t              state_nxt;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    logic [STARVE_CNT_W-1:0] starve_nxt;
    logic                    load;
    logic                    sel_d;
    logic                    done;
    logic [63:0]             lat_addr;
    logic [2:0]              lat_size;
    logic [7:0]              lat_strobe;
    logic [63:0]             lat_data;

    // Completion only counts while a grant is outstanding; ready in IDLE is ignored.
    assign done = (state != IDLE) && mresp.ready && mresp.last;

    // State and starvation counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= state_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    // Grant decision: dbus priority, ibus forced through once starve_cnt hits the limit.
    always_comb begin
        state_nxt  = state;
        starve_nxt = starve_cnt;
        load       = 1'b0;
        sel_d      = 1'b0;
        case (state)
            IDLE: begin
                if (!ireq.valid) begin
                    starve_nxt = '0;
                end
                if (dreq.valid && (!ireq.valid || (starve_cnt < STARVE_LIM))) begin
                    state_nxt = GRANT_D;
                    load      = 1'b1;
                    sel_d     = 1'b1;
                    if (ireq.valid && (starve_cnt < STARVE_LIM)) begin
                        starve_nxt = starve_cnt + CNT_ONE;
                    end
                end else if (ireq.valid) begin
                    state_nxt  = GRANT_I;
                    load       = 1'b1;
                    starve_nxt = '0;
                end
            end
            GRANT_I, GRANT_D: begin
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    mem_req_latch u_latch (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .new_addr   (sel_d ? dreq.addr : ireq.addr),
        .new_size   (sel_d ? dreq.size : 3'b010),
        .new_strobe (sel_d ? dreq.strobe : 8'h00),
        .new_data   (sel_d ? dreq.data : 64'h0),
        .addr       (lat_addr),
        .size       (lat_size),
        .strobe     (lat_strobe),
        .data       (lat_data)
    );

    // Memory request and per-port response pulses; data is zero unless completing.
    always_comb begin
        mreq.valid    = (state != IDLE);
        mreq.is_write = (lat_strobe != 8'h00);
        mreq.size     = lat_size;
        mreq.addr     = lat_addr;
        mreq.strobe   = lat_strobe;
        mreq.data     = lat_data;
        iresp         = '0;
        dresp         = '0;
        if (done && (state == GRANT_I)) begin
            iresp.addr_ok = 1'b1;
            iresp.data_ok = 1'b1;
            iresp.data    = lat_addr[2] ? mresp.data[63:32] : mresp.data[31:0];
        end
        if (done && (state == GRANT_D)) begin
            dresp.addr_ok = 1'b1;
            dresp.data_ok = 1'b1;
            dresp.data    = mresp.data;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Latency: checks grant-edge and completion-cycle timing.
// Backpressure: exercises starvation limit and ignored idle ready.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    ibus_req_t  ireq;
    ibus_resp_t iresp;
    dbus_req_t  dreq;
    dbus_resp_t dresp;
    cbus_req_t  mreq;
    cbus_resp_t mresp;
    int         n_run = 0;
    int         n_fail = 0;

    mem_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .ireq  (ireq),
        .iresp (iresp),
        .dreq  (dreq),
        .dresp (dresp),
        .mreq  (mreq),
        .mresp (mresp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ireq  = '0;
        dreq  = '0;
        mresp = '0;
        #2;
        n_run++; if (mreq.valid !== 1'b0) begin n_fail++; $display("FAIL reset_mreq_valid: got %0b want 0", mreq.valid); end
        n_run++; if (mreq.addr !== 64'h0) begin n_fail++; $display("FAIL reset_mreq_addr: got %0h want 0", mreq.addr); end
        n_run++; if ({iresp.addr_ok, iresp.data_ok, dresp.addr_ok, dresp.data_ok} !== 4'b0) begin n_fail++; $display("FAIL reset_oks: got %b want 0000", {iresp.addr_ok, iresp.data_ok, dresp.addr_ok, dresp.data_ok}); end
        n_run++; if (dut.starve_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_starve: got %0d want 0", dut.starve_cnt); end
        #10 reset = 1'b1;
        tick();
    endtask

    task automatic test_ifetch();
        ireq.valid = 1'b1;
        ireq.addr  = 64'h8000_0004;
        mresp.data = 64'h1111_2222_3333_4444;
        tick();
        ireq.valid = 1'b0;
        #1;
        n_run++; if (mreq.valid !== 1'b1 || mreq.addr !== 64'h8000_0004) begin n_fail++; $display("FAIL ifetch_grant: got v=%0b a=%0h want v=1 a=80000004", mreq.valid, mreq.addr); end
        n_run++; if (mreq.size !== 3'b010 || mreq.is_write !== 1'b0 || mreq.strobe !== 8'h0) begin n_fail++; $display("FAIL ifetch_fields: got sz=%0d w=%0b st=%0h want 2 0 0", mreq.size, mreq.is_write, mreq.strobe); end
        n_run++; if (iresp.data_ok !== 1'b0 || iresp.data !== 32'h0) begin n_fail++; $display("FAIL ifetch_early: got ok=%0b d=%0h want 0 0", iresp.data_ok, iresp.data); end
        tick();
        tick();
        mresp.ready = 1'b1;
        mresp.last  = 1'b1;
        #1;
        n_run++; if (iresp.data_ok !== 1'b1 || iresp.addr_ok !== 1'b1) begin n_fail++; $display("FAIL ifetch_pulse: got a=%0b d=%0b want 1 1", iresp.addr_ok, iresp.data_ok); end
        n_run++; if (iresp.data !== 32'h1111_2222) begin n_fail++; $display("FAIL ifetch_data: got %0h want 11112222", iresp.data); end
        n_run++; if (dresp.data_ok !== 1'b0) begin n_fail++; $display("FAIL ifetch_dresp: got %0b want 0", dresp.data_ok); end
        tick();
        mresp.ready = 1'b0;
        mresp.last  = 1'b0;
        #1;
        n_run++; if (mreq.valid !== 1'b0 || iresp.data_ok !== 1'b0) begin n_fail++; $display("FAIL ifetch_idle: got v=%0b ok=%0b want 0 0", mreq.valid, iresp.data_ok); end
    endtask

    task automatic test_contention();
        ireq.valid  = 1'b1;
        ireq.addr   = 64'h200;
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h100;
        dreq.size   = 3'b011;
        dreq.strobe = 8'hFF;
        dreq.data   = 64'hDEAD;
        tick();
        dreq.valid  = 1'b0;
        mresp.ready = 1'b1;
        mresp.last  = 1'b1;
        mresp.data  = 64'hCAFE;
        #1;
        n_run++; if (mreq.is_write !== 1'b1 || mreq.addr !== 64'h100 || mreq.data !== 64'hDEAD || mreq.strobe !== 8'hFF) begin n_fail++; $display("FAIL contend_dgrant: got w=%0b a=%0h d=%0h s=%0h want 1 100 dead ff", mreq.is_write, mreq.addr, mreq.data, mreq.strobe); end
        n_run++; if (dresp.data_ok !== 1'b1 || dresp.data !== 64'hCAFE || iresp.data_ok !== 1'b0) begin n_fail++; $display("FAIL contend_dresp: got ok=%0b d=%0h iok=%0b want 1 cafe 0", dresp.data_ok, dresp.data, iresp.data_ok); end
        tick();
        mresp.ready = 1'b0;
        mresp.last  = 1'b0;
        #1;
        n_run++; if (mreq.valid !== 1'b0) begin n_fail++; $display("FAIL contend_gap: got %0b want 0", mreq.valid); end
        tick();
        mresp.ready = 1'b1;
        mresp.last  = 1'b1;
        mresp.data  = 64'h1111_2222_3333_4444;
        ireq.valid  = 1'b0;
        #1;
        n_run++; if (mreq.valid !== 1'b1 || mreq.addr !== 64'h200 || mreq.is_write !== 1'b0) begin n_fail++; $display("FAIL contend_igrant: got v=%0b a=%0h w=%0b want 1 200 0", mreq.valid, mreq.addr, mreq.is_write); end
        n_run++; if (iresp.data_ok !== 1'b1 || iresp.data !== 32'h3333_4444) begin n_fail++; $display("FAIL contend_iresp: got ok=%0b d=%0h want 1 33334444", iresp.data_ok, iresp.data); end
        tick();
        mresp.ready = 1'b0;
        mresp.last  = 1'b0;
    endtask

    task automatic test_starve();
        logic [63:0] exp_addr;
        logic [3:0]  exp_cnt;
        ireq.valid  = 1'b1;
        ireq.addr   = 64'h208;
        dreq.valid  = 1'b1;
        dreq.addr   = 64'h100;
        dreq.strobe = 8'hFF;
        for (int k = 0; k < 5; k++) begin
            exp_addr = (k < 4) ? 64'h100 : 64'h208;
            exp_cnt  = (k < 4) ? 4'(k + 1) : 4'd0;
            tick();
            mresp.ready = 1'b1;
            mresp.last  = 1'b1;
            #1;
            n_run++; if (mreq.valid !== 1'b1 || mreq.addr !== exp_addr) begin n_fail++; $display("FAIL starve_grant%0d: got v=%0b a=%0h want 1 %0h", k, mreq.valid, mreq.addr, exp_addr); end
            n_run++; if (dut.starve_cnt !== exp_cnt) begin n_fail++; $display("FAIL starve_cnt%0d: got %0d want %0d", k, dut.starve_cnt, exp_cnt); end
            tick();
            mresp.ready = 1'b0;
            mresp.last  = 1'b0;
            #1;
            n_run++; if (mreq.valid !== 1'b0) begin n_fail++; $display("FAIL starve_gap%0d: got %0b want 0", k, mreq.valid); end
        end
        ireq.valid = 1'b0;
        dreq.valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        dreq.valid = 1'b1;
        dreq.addr  = 64'h300;
        mresp.data = 64'h5555;
        tick();
        dreq.valid = 1'b0;
        tick();
        mresp.ready = 1'b1;
        mresp.last  = 1'b1;
        reset       = 1'b0;
        #1;
        n_run++; if (mreq.valid !== 1'b0 || dresp.data_ok !== 1'b0) begin n_fail++; $display("FAIL rstmid_abort: got v=%0b ok=%0b want 0 0", mreq.valid, dresp.data_ok); end
        n_run++; if (mreq.addr !== 64'h0) begin n_fail++; $display("FAIL rstmid_addr: got %0h want 0", mreq.addr); end
        mresp.ready = 1'b0;
        mresp.last  = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        n_run++; if (mreq.valid !== 1'b0 || dresp.data_ok !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle: got v=%0b ok=%0b want 0 0", mreq.valid, dresp.data_ok); end
    endtask

    task automatic test_drop_valid();
        ireq.valid = 1'b1;
        ireq.addr  = 64'h4000;
        mresp.data = 64'hAAAA_BBBB_CCCC_DDDD;
        tick();
        ireq.valid = 1'b0;
        ireq.addr  = 64'hFFFF_0000;
        #1;
        n_run++; if (mreq.valid !== 1'b1 || mreq.addr !== 64'h4000) begin n_fail++; $display("FAIL drop_hold1: got v=%0b a=%0h want 1 4000", mreq.valid, mreq.addr); end
        tick();
        n_run++; if (mreq.valid !== 1'b1 || mreq.addr !== 64'h4000) begin n_fail++; $display("FAIL drop_hold2: got v=%0b a=%0h want 1 4000", mreq.valid, mreq.addr); end
        mresp.ready = 1'b1;
        mresp.last  = 1'b1;
        #1;
        n_run++; if (iresp.data_ok !== 1'b1 || iresp.data !== 32'hCCCC_DDDD) begin n_fail++; $display("FAIL drop_pulse: got ok=%0b d=%0h want 1 ccccdddd", iresp.data_ok, iresp.data); end
        tick();
        mresp.ready = 1'b0;
        mresp.last  = 1'b0;
        #1;
        n_run++; if (mreq.valid !== 1'b0) begin n_fail++; $display("FAIL drop_idle: got %0b want 0", mreq.valid); end
    endtask

    task automatic test_idle_ready();
        mresp.ready = 1'b1;
        mresp.last  = 1'b1;
        mresp.data  = 64'h1234_5678_9ABC_DEF0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_run++; if (mreq.valid !== 1'b0 || iresp.data_ok !== 1'b0 || dresp.data_ok !== 1'b0 || dresp.data !== 64'h0 || iresp.data !== 32'h0) begin n_fail++; $display("FAIL idle_ready%0d: got v=%0b iok=%0b dok=%0b dd=%0h want all 0", k, mreq.valid, iresp.data_ok, dresp.data_ok, dresp.data); end
        end
        mresp.ready = 1'b0;
        mresp.last  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_contention();
        test_starve();
        test_reset_mid();
        test_drop_valid();
        test_idle_ready();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
